// File: rtl/vline_fetch.sv
// vline_fetch: streams one video line of 16-bit RAM words into the line buffer.
// Optional return watchdog enabled by defining VLINE_FETCH_TIMEOUT_EN.
module vline_fetch #(
    parameter int ADDR_W    = 19,
    parameter int WORDS     = 128,
    parameter int MAX_OUTST = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic              i_clk_mem,
    input  logic              i_reset,
    input  logic              i_line_start,
    input  logic [ADDR_W-1:0] i_line_base,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic              i_mem_rdata_valid,
    input  logic [15:0]       i_mem_rdata,
    output logic              o_vdata_reset,
    output logic              o_vdata_valid,
    output logic [15:0]       o_vdata,
    output logic              o_timeout
);

    localparam int CW = $clog2(WORDS) + 1;
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] WORDS_C = CW'(WORDS);
    localparam logic [OW-1:0] MAXO_C  = OW'(MAX_OUTST);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_FETCH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     issued_q, issued_d;
    logic [CW-1:0]     rcvd_q, rcvd_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
    logic              rd_q, rd_d;
    logic              vreset_q, vreset_d;
    logic              vvalid_q, vvalid_d;
    logic [15:0]       vdata_q, vdata_d;
    logic              ack_ok, ret_ok;

`ifdef VLINE_FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_C = TW'(TIMEOUT);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          timeout_q, timeout_d;
`endif

    assign ack_ok = rd_q & i_mem_ack;
    // Returns with nothing in flight, or outside FETCH, are stray and dropped.
    assign ret_ok = (state_q == S_FETCH) & i_mem_rdata_valid & (outst_q != '0);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        issued_d = issued_q;
        rcvd_d   = rcvd_q;
        outst_d  = outst_q;
        vdata_d  = vdata_q;
        vvalid_d = 1'b0;
        vreset_d = 1'b0;
        done_d   = 1'b0;
        ovr_d    = ovr_q | (i_line_start & (state_q != S_IDLE));
`ifdef VLINE_FETCH_TIMEOUT_EN
        tmo_d     = tmo_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_line_start) begin
                    state_d  = S_CLEAR;
                    addr_d   = i_line_base;
                    issued_d = '0;
                    rcvd_d   = '0;
                    outst_d  = '0;
                    vreset_d = 1'b1;
`ifdef VLINE_FETCH_TIMEOUT_EN
                    tmo_d = '0;
`endif
                end
            end
            S_CLEAR: state_d = S_FETCH;
            S_FETCH: begin
                if (ack_ok) begin
                    addr_d   = addr_q + 1'b1;
                    issued_d = issued_q + 1'b1;
                end
                if (ret_ok) begin
                    rcvd_d   = rcvd_q + 1'b1;
                    vvalid_d = 1'b1;
                    vdata_d  = i_mem_rdata;
                end
                case ({ack_ok, ret_ok})
                    2'b10:   outst_d = outst_q + 1'b1;
                    2'b01:   outst_d = outst_q - 1'b1;
                    default: outst_d = outst_q;
                endcase
                if (rcvd_d == WORDS_C) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
`ifdef VLINE_FETCH_TIMEOUT_EN
                if (i_mem_rdata_valid) begin
                    tmo_d = '0;
                end else if (outst_q != '0) begin
                    tmo_d = tmo_q + 1'b1;
                end
                if (state_d == S_FETCH && tmo_d == TMO_C) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        rd_d   = (state_d == S_FETCH) & (issued_d < WORDS_C) & (outst_d < MAXO_C);
    end

    always_ff @(posedge i_clk_mem) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            issued_q <= '0;
            rcvd_q   <= '0;
            outst_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            rd_q     <= 1'b0;
            vreset_q <= 1'b0;
            vvalid_q <= 1'b0;
            vdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            issued_q <= issued_d;
            rcvd_q   <= rcvd_d;
            outst_q  <= outst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            rd_q     <= rd_d;
            vreset_q <= vreset_d;
            vvalid_q <= vvalid_d;
            vdata_q  <= vdata_d;
        end
    end

`ifdef VLINE_FETCH_TIMEOUT_EN
    always_ff @(posedge i_clk_mem) begin
        if (i_reset) begin
            tmo_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_overrun     = ovr_q;
    assign o_mem_rd      = rd_q;
    assign o_mem_addr    = addr_q;
    assign o_vdata_reset = vreset_q;
    assign o_vdata_valid = vvalid_q;
    assign o_vdata       = vdata_q;

endmodule
